// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_arb_pkg
// Description : Shared types for the two-master AXI read-address arbiter:
//               FSM state encoding, master index type and the default
//               address tag that selects slave S1.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_t;

  localparam logic [15:0] S1_TAG_DEFAULT = 16'h0001;

endpackage : axi_arb_pkg
`default_nettype wire

// File: rtl/read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : read_arbiter_if
// Description : Bundle of the master AR requests, the selected-slave AR/R
//               handshake and the arbiter status outputs.
// Modports    : slave  - arbiter side (requests/handshakes in, status out)
//               master - environment side (drives requests/handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
interface read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) ();

  logic              arvalid_m0;
  logic              arvalid_m1;
  logic [ADDR_W-1:0] araddr_m0;
  logic [ADDR_W-1:0] araddr_m1;
  logic [LEN_W-1:0]  arlen_m0;
  logic [LEN_W-1:0]  arlen_m1;
  logic              arready_s;
  logic              rvalid_s;
  logic              rready_m;
  logic              rlast_s;
  logic [1:0]        gnt;
  logic              sel_s1;
  logic              busy;
  logic [LEN_W-1:0]  beat_cnt;
  logic              len_err;

  modport slave (
    input  arvalid_m0, arvalid_m1, araddr_m0, araddr_m1, arlen_m0, arlen_m1,
    input  arready_s, rvalid_s, rready_m, rlast_s,
    output gnt, sel_s1, busy, beat_cnt, len_err
  );

  modport master (
    output arvalid_m0, arvalid_m1, araddr_m0, araddr_m1, arlen_m0, arlen_m1,
    output arready_s, rvalid_s, rready_m, rlast_s,
    input  gnt, sel_s1, busy, beat_cnt, len_err
  );

endinterface : read_arbiter_if
`default_nettype wire

// File: rtl/read_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : read_beat_counter
// Description : Counts accepted R beats of the current burst, holds the
//               granted burst length and flags RLAST/length mismatches.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_load, i_len - latch burst length (on grant)
//               i_clear       - zero the beat count (on AR handshake)
//               i_beat        - R handshake accepted in DATA
//               i_last        - RLAST of that handshake
//               o_beat_cnt    - beats accepted so far (saturating)
//               o_len_err     - one-cycle mismatch pulse
// Revision    : 1.0 - initial release
// ============================================================================
module read_beat_counter #(
  parameter int LEN_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [LEN_W-1:0] i_len,
  input  wire logic             i_clear,
  input  wire logic             i_beat,
  input  wire logic             i_last,
  output logic      [LEN_W-1:0] o_beat_cnt,
  output logic                  o_len_err
);

  localparam logic [LEN_W-1:0] C_CNT_MAX = {LEN_W{1'b1}};

  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_len_err;

  // The count seen here is the number of beats before the current one, so
  // the final beat of a well-formed burst arrives when r_cnt equals arlen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= i_beat && (i_last != (r_cnt == r_len));
      if (i_load) begin
        r_len <= i_len;
      end
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_beat && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_beat_cnt = r_cnt;
  assign o_len_err  = r_len_err;

endmodule : read_beat_counter
`default_nettype wire

// File: rtl/read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : read_arbiter
// Description : Two-master AXI read arbiter. Grants one master from IDLE,
//               routes it to S0/S1 by address tag, waits for the AR
//               handshake, then tracks R beats until RLAST. Simultaneous
//               requests alternate via a priority bit.
// Ports       : clk - clock; rst - synchronous active-high reset
//               bus - read_arbiter_if.slave (requests, handshakes, status)
// Revision    : 1.0 - initial release
// ============================================================================
module read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          LEN_W  = 4,
  parameter logic [15:0] S1_TAG = S1_TAG_DEFAULT
) (
  input wire logic      clk,
  input wire logic      rst,
  read_arbiter_if.slave bus
);

  state_t     r_state;
  logic [1:0] r_gnt;
  logic       r_sel_s1;
  mst_t       r_prio;
  mst_t       r_gidx;

  state_t           w_state_nxt;
  logic [1:0]       w_gnt_nxt;
  logic             w_sel_nxt;
  mst_t             w_prio_nxt;
  mst_t             w_gidx_nxt;
  mst_t             w_winner;
  logic [LEN_W-1:0] w_len_sel;
  logic             w_grant;
  logic             w_ar_hs;
  logic             w_beat;
  logic             w_gnt_valid;

  // Only the tag field takes part in routing.
  wire w_unused_addr = ^{bus.araddr_m0[15:0], bus.araddr_m1[15:0]};

  assign w_gnt_valid = (r_gidx == MST_M1) ? bus.arvalid_m1 : bus.arvalid_m0;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel_s1;
    w_prio_nxt  = r_prio;
    w_gidx_nxt  = r_gidx;
    w_winner    = MST_M0;
    w_len_sel   = bus.arlen_m0;
    w_grant     = 1'b0;
    w_ar_hs     = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.arvalid_m0 || bus.arvalid_m1) begin
          if (bus.arvalid_m0 && bus.arvalid_m1) begin
            w_winner = r_prio;
          end else if (bus.arvalid_m1) begin
            w_winner = MST_M1;
          end else begin
            w_winner = MST_M0;
          end
          w_grant     = 1'b1;
          w_state_nxt = ST_ADDR;
          w_gidx_nxt  = w_winner;
          if (w_winner == MST_M1) begin
            w_gnt_nxt = 2'b10;
            w_sel_nxt = (bus.araddr_m1[31:16] == S1_TAG);
            w_len_sel = bus.arlen_m1;
          end else begin
            w_gnt_nxt = 2'b01;
            w_sel_nxt = (bus.araddr_m0[31:16] == S1_TAG);
            w_len_sel = bus.arlen_m0;
          end
        end
      end
      ST_ADDR: begin
        // A dropped arvalid simply parks here; the grant is not revoked.
        if (w_gnt_valid && bus.arready_s) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_beat = bus.rvalid_s && bus.rready_m;
        // Only RLAST ends the burst, even when the length disagrees.
        if (w_beat && bus.rlast_s) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
          w_prio_nxt  = (r_gidx == MST_M0) ? MST_M1 : MST_M0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 2'b00;
      r_sel_s1 <= 1'b0;
      r_prio   <= MST_M0;
      r_gidx   <= MST_M0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_sel_s1 <= w_sel_nxt;
      r_prio   <= w_prio_nxt;
      r_gidx   <= w_gidx_nxt;
    end
  end

  read_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_grant),
    .i_len      (w_len_sel),
    .i_clear    (w_ar_hs),
    .i_beat     (w_beat),
    .i_last     (bus.rlast_s),
    .o_beat_cnt (bus.beat_cnt),
    .o_len_err  (bus.len_err)
  );

  assign bus.gnt    = r_gnt;
  assign bus.sel_s1 = r_sel_s1;
  assign bus.busy   = (r_state != ST_IDLE);

endmodule : read_arbiter
`default_nettype wire

// File: tb/tb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_read_arbiter
// Description : Directed self-checking bench for read_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_read_arbiter;
  import axi_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  read_arbiter_if #(.ADDR_W(32), .LEN_W(4)) bus_if ();

  read_arbiter #(
    .ADDR_W (32),
    .LEN_W  (4),
    .S1_TAG (16'h0001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input logic last);
    bus_if.rvalid_s = 1'b1;
    bus_if.rready_m = 1'b1;
    bus_if.rlast_s  = last;
    tick();
    bus_if.rvalid_s = 1'b0;
    bus_if.rready_m = 1'b0;
    bus_if.rlast_s  = 1'b0;
  endtask

  task automatic ar_hs();
    bus_if.arready_s = 1'b1;
    tick();
    bus_if.arready_s = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus_if.arvalid_m0 = 1'b0;
    bus_if.arvalid_m1 = 1'b0;
    bus_if.araddr_m0  = '0;
    bus_if.araddr_m1  = '0;
    bus_if.arlen_m0   = '0;
    bus_if.arlen_m1   = '0;
    bus_if.arready_s  = 1'b0;
    bus_if.rvalid_s   = 1'b0;
    bus_if.rready_m   = 1'b0;
    bus_if.rlast_s    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_gnt",      32'(bus_if.gnt),      32'h0);
    chk("rst_sel",      32'(bus_if.sel_s1),   32'h0);
    chk("rst_busy",     32'(bus_if.busy),     32'h0);
    chk("rst_beat_cnt", 32'(bus_if.beat_cnt), 32'h0);
    chk("rst_len_err",  32'(bus_if.len_err),  32'h0);
    chk("rst_prio",     32'(dut.r_prio),      32'h0);

    // Single M0 burst to S1, arlen=3, four beats
    bus_if.arvalid_m0 = 1'b1;
    bus_if.araddr_m0  = 32'h0001_0000;
    bus_if.arlen_m0   = 4'd3;
    tick();
    chk("t1_gnt",  32'(bus_if.gnt),    32'h1);
    chk("t1_sel",  32'(bus_if.sel_s1), 32'h1);
    chk("t1_busy", 32'(bus_if.busy),   32'h1);
    ar_hs();
    bus_if.arvalid_m0 = 1'b0;
    chk("t1_state_data", 32'(dut.r_state), 32'(ST_DATA));
    chk("t1_cnt0",       32'(bus_if.beat_cnt), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      beat(1'b0);
      chk("t1_cnt",     32'(bus_if.beat_cnt), 32'(i));
      chk("t1_len_err", 32'(bus_if.len_err),  32'h0);
      chk("t1_gnt_mid", 32'(bus_if.gnt),      32'h1);
    end
    beat(1'b1);
    chk("t1_end_gnt",  32'(bus_if.gnt),      32'h0);
    chk("t1_end_busy", 32'(bus_if.busy),     32'h0);
    chk("t1_end_err",  32'(bus_if.len_err),  32'h0);
    chk("t1_end_cnt",  32'(bus_if.beat_cnt), 32'h4);

    // Simultaneous requests: M0 first, M1 after one IDLE cycle, then M0
    do_reset();
    bus_if.arvalid_m0 = 1'b1;
    bus_if.araddr_m0  = 32'h0000_1234;
    bus_if.arlen_m0   = 4'd0;
    bus_if.arvalid_m1 = 1'b1;
    bus_if.araddr_m1  = 32'h0001_8000;
    bus_if.arlen_m1   = 4'd0;
    tick();
    chk("t2_gnt_m0", 32'(bus_if.gnt),    32'h1);
    chk("t2_sel_s0", 32'(bus_if.sel_s1), 32'h0);
    ar_hs();
    bus_if.arvalid_m0 = 1'b0;
    beat(1'b1);
    chk("t2_idle_busy", 32'(bus_if.busy), 32'h0);
    chk("t2_idle_gnt",  32'(bus_if.gnt),  32'h0);
    tick();
    chk("t2_gnt_m1", 32'(bus_if.gnt),    32'h2);
    chk("t2_sel_s1", 32'(bus_if.sel_s1), 32'h1);
    ar_hs();
    bus_if.arvalid_m0 = 1'b1;
    beat(1'b1);
    chk("t2_prio_back", 32'(dut.r_prio), 32'h0);
    tick();
    chk("t2_third_gnt", 32'(bus_if.gnt), 32'h1);
    ar_hs();
    bus_if.arvalid_m0 = 1'b0;
    bus_if.arvalid_m1 = 1'b0;
    beat(1'b1);
    chk("t2_prio_m1", 32'(dut.r_prio), 32'h1);

    // M1 in DATA, M0 request must wait; non-tag address routes to S0
    do_reset();
    bus_if.arvalid_m1 = 1'b1;
    bus_if.araddr_m1  = 32'h0002_0000;
    bus_if.arlen_m1   = 4'd1;
    tick();
    chk("t3_gnt_m1", 32'(bus_if.gnt),    32'h2);
    chk("t3_sel_s0", 32'(bus_if.sel_s1), 32'h0);
    ar_hs();
    bus_if.arvalid_m1 = 1'b0;
    bus_if.arvalid_m0 = 1'b1;
    bus_if.araddr_m0  = 32'h0001_0004;
    bus_if.arlen_m0   = 4'd0;
    tick();
    chk("t3_hold_gnt", 32'(bus_if.gnt), 32'h2);
    beat(1'b0);
    chk("t3_hold_gnt2", 32'(bus_if.gnt),     32'h2);
    chk("t3_err0",      32'(bus_if.len_err), 32'h0);
    beat(1'b1);
    chk("t3_end_gnt", 32'(bus_if.gnt),     32'h0);
    chk("t3_err1",    32'(bus_if.len_err), 32'h0);
    tick();
    chk("t3_gnt_m0", 32'(bus_if.gnt),    32'h1);
    chk("t3_sel_s1", 32'(bus_if.sel_s1), 32'h1);
    ar_hs();
    bus_if.arvalid_m0 = 1'b0;
    beat(1'b1);

    // arlen=2 but rlast on beat 2
    do_reset();
    bus_if.arvalid_m0 = 1'b1;
    bus_if.araddr_m0  = 32'h0000_0000;
    bus_if.arlen_m0   = 4'd2;
    tick();
    ar_hs();
    bus_if.arvalid_m0 = 1'b0;
    beat(1'b0);
    chk("t4a_err_b1", 32'(bus_if.len_err), 32'h0);
    beat(1'b1);
    chk("t4a_err_b2", 32'(bus_if.len_err), 32'h1);
    chk("t4a_idle",   32'(bus_if.busy),    32'h0);
    chk("t4a_gnt",    32'(bus_if.gnt),     32'h0);
    tick();
    chk("t4a_pulse_end", 32'(bus_if.len_err), 32'h0);

    // arlen=1, no rlast on beat 2, rlast on beat 3
    bus_if.arvalid_m0 = 1'b1;
    bus_if.arlen_m0   = 4'd1;
    tick();
    ar_hs();
    bus_if.arvalid_m0 = 1'b0;
    beat(1'b0);
    chk("t4b_err_b1", 32'(bus_if.len_err), 32'h0);
    beat(1'b0);
    chk("t4b_err_b2", 32'(bus_if.len_err),  32'h1);
    chk("t4b_busy",   32'(bus_if.busy),     32'h1);
    chk("t4b_cnt",    32'(bus_if.beat_cnt), 32'h2);
    beat(1'b1);
    chk("t4b_err_b3", 32'(bus_if.len_err), 32'h1);
    chk("t4b_idle",   32'(bus_if.busy),    32'h0);
    tick();
    chk("t4b_pulse_end", 32'(bus_if.len_err), 32'h0);
    chk("t4b_prio",      32'(dut.r_prio),     32'h1);

    // Reset during DATA beat 1 (a beat that would otherwise flag an error)
    bus_if.arvalid_m0 = 1'b1;
    bus_if.arlen_m0   = 4'd3;
    tick();
    ar_hs();
    bus_if.arvalid_m0 = 1'b0;
    bus_if.rvalid_s   = 1'b1;
    bus_if.rready_m   = 1'b1;
    bus_if.rlast_s    = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.rvalid_s = 1'b0;
    bus_if.rready_m = 1'b0;
    bus_if.rlast_s  = 1'b0;
    chk("t5_gnt",  32'(bus_if.gnt),      32'h0);
    chk("t5_busy", 32'(bus_if.busy),     32'h0);
    chk("t5_cnt",  32'(bus_if.beat_cnt), 32'h0);
    chk("t5_prio", 32'(dut.r_prio),      32'h0);
    chk("t5_err",  32'(bus_if.len_err),  32'h0);

    // arready held low five cycles; R traffic in ADDR is ignored
    bus_if.arvalid_m1 = 1'b1;
    bus_if.araddr_m1  = 32'h0001_0000;
    bus_if.arlen_m1   = 4'd0;
    tick();
    chk("t6_gnt", 32'(bus_if.gnt), 32'h2);
    bus_if.rvalid_s = 1'b1;
    bus_if.rready_m = 1'b1;
    bus_if.rlast_s  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_gnt_hold",   32'(bus_if.gnt),     32'h2);
      chk("t6_state_addr", 32'(dut.r_state),    32'(ST_ADDR));
      chk("t6_err",        32'(bus_if.len_err), 32'h0);
    end
    bus_if.arvalid_m1 = 1'b0;
    bus_if.arready_s  = 1'b1;
    tick();
    chk("t6_drop_state", 32'(dut.r_state), 32'(ST_ADDR));
    chk("t6_drop_gnt",   32'(bus_if.gnt),  32'h2);
    bus_if.arvalid_m1 = 1'b1;
    tick();
    bus_if.arvalid_m1 = 1'b0;
    bus_if.arready_s  = 1'b0;
    bus_if.rvalid_s   = 1'b0;
    bus_if.rready_m   = 1'b0;
    bus_if.rlast_s    = 1'b0;
    chk("t6_state_data", 32'(dut.r_state),    32'(ST_DATA));
    chk("t6_cnt0",       32'(bus_if.beat_cnt), 32'h0);
    beat(1'b1);
    chk("t6_end_busy", 32'(bus_if.busy),    32'h0);
    chk("t6_end_err",  32'(bus_if.len_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_read_arbiter
`default_nettype wire
